// File: rtl/cmd_input_ctrl_pkg.sv
// Shared constants for the command front end and envolve_ctrl: command bit
// indices, direction indices, mode encodings and the wrap-around cursor step.
package cmd_input_ctrl_pkg;

  localparam int CMD_TOGGLE  = 0;
  localparam int CMD_RUN     = 1;
  localparam int CMD_STEP    = 2;
  localparam int CMD_RANDOM  = 3;
  localparam int CMD_CLEAR   = 4;
  localparam int CMD_PATTERN = 5;
  localparam int CMD_SPD_UP  = 6;
  localparam int CMD_SPD_DN  = 7;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam logic MODE_EDIT = 1'b0;
  localparam logic MODE_RUN  = 1'b1;

  localparam int NUM_DIR = 4;
  localparam int NUM_CMD = 8;
  localparam int NUM_BTN = NUM_DIR + NUM_CMD;

  // Opposing moves in the same cycle cancel; otherwise step with wrap at both ends.
  function automatic logic [7:0] cursor_step(input logic [7:0] pos,
                                             input logic       inc,
                                             input logic       dec,
                                             input logic [7:0] max_pos);
    logic [7:0] nxt;
    nxt = pos;
    if (inc && !dec) begin
      nxt = (pos == max_pos) ? 8'd0 : pos + 8'd1;
    end else if (dec && !inc) begin
      nxt = (pos == 8'd0) ? max_pos : pos - 8'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cmd_input_ctrl_btn_debounce.sv
// One button lane: 2-FF synchroniser, stability counter, registered rising-edge pulse.
// The stable value only changes after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_stable_prev;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_stable      <= 1'b0;
      r_stable_prev <= 1'b0;
      r_rise        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_sync1       <= raw;
      r_sync2       <= r_sync1;
      r_stable_prev <= r_stable;
      r_rise        <= r_stable & ~r_stable_prev;
      // Any matching sample restarts the count, so short glitches are discarded.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stable = r_stable;
  assign rise   = r_rise;

endmodule

// File: rtl/cmd_input_ctrl.sv
// Button front end for envolve_ctrl: debounced command pulses, run/edit mode, edit cursor.
// Optional direction auto-repeat is built when CMD_AUTOREPEAT_EN is defined.
module cmd_input_ctrl
  import cmd_input_ctrl_pkg::*;
#(
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 32,
`ifdef CMD_AUTOREPEAT_EN
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
`endif
  parameter int DEB_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_dir,
  input  logic [7:0] btn_cmd,
  output logic [7:0] envo_ctrl_cmd,
  output logic       mode,
  output logic [7:0] cur_x,
  output logic [7:0] cur_y
);

  localparam logic [7:0] X_MAX = 8'(GRID_W - 1);
  localparam logic [7:0] Y_MAX = 8'(GRID_H - 1);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_rise;
  logic [3:0]         w_dir_pulse;
  logic [7:0]         w_cmd_pulse;
  logic [7:0]         w_cmd_out;
  logic               w_force_edit;
  logic               w_mode_nxt;
  logic [7:0]         w_cur_x_nxt;
  logic [7:0]         w_cur_y_nxt;

  logic [7:0]         r_cmd;
  logic               r_mode;
  logic [7:0]         r_cur_x;
  logic [7:0]         r_cur_y;

  assign w_raw = {btn_cmd, btn_dir};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_lane
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (w_raw[g]),
      .stable(w_stable[g]),
      .rise  (w_rise[g])
    );
  end

`ifdef CMD_AUTOREPEAT_EN
  localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] r_rep_cnt [NUM_DIR];
  logic [3:0]    r_rep_first;
  logic [3:0]    w_rep_fire;

  // Count cycles since the last emitted pulse; the first gap is REP_DELAY, later ones REP_PERIOD.
  always_comb begin
    w_rep_fire = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (w_stable[d] && !w_rise[d]) begin
        w_rep_fire[d] = r_rep_first[d] ? (r_rep_cnt[d] == RW'(REP_DELAY))
                                       : (r_rep_cnt[d] == RW'(REP_PERIOD));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < NUM_DIR; d++) begin
        r_rep_cnt[d] <= '0;
      end
      r_rep_first <= '0;
    end else begin
      for (int d = 0; d < NUM_DIR; d++) begin
        if (!w_stable[d]) begin
          r_rep_cnt[d]   <= '0;
          r_rep_first[d] <= 1'b0;
        end else if (w_rise[d]) begin
          r_rep_cnt[d]   <= RW'(1);
          r_rep_first[d] <= 1'b1;
        end else if (w_rep_fire[d]) begin
          r_rep_cnt[d]   <= RW'(1);
          r_rep_first[d] <= 1'b0;
        end else begin
          r_rep_cnt[d] <= r_rep_cnt[d] + 1'b1;
        end
      end
    end
  end

  assign w_dir_pulse = w_rise[3:0] | w_rep_fire;
`else
  assign w_dir_pulse = w_rise[3:0];
`endif

  assign w_cmd_pulse  = w_rise[NUM_BTN-1:NUM_DIR];
  assign w_force_edit = w_cmd_pulse[CMD_CLEAR] | w_cmd_pulse[CMD_RANDOM] |
                        w_cmd_pulse[CMD_PATTERN];

  // Editing commands are gated on the mode held before this update.
  always_comb begin
    w_cmd_out = w_cmd_pulse;
    if (r_mode == MODE_RUN) begin
      w_cmd_out[CMD_TOGGLE] = 1'b0;
      w_cmd_out[CMD_STEP]   = 1'b0;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_force_edit) begin
      w_mode_nxt = MODE_EDIT;
    end else if (w_cmd_pulse[CMD_RUN]) begin
      w_mode_nxt = ~r_mode;
    end
  end

  assign w_cur_x_nxt = cursor_step(r_cur_x, w_dir_pulse[DIR_RIGHT], w_dir_pulse[DIR_LEFT], X_MAX);
  assign w_cur_y_nxt = cursor_step(r_cur_y, w_dir_pulse[DIR_DOWN], w_dir_pulse[DIR_UP], Y_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd   <= '0;
      r_mode  <= MODE_EDIT;
      r_cur_x <= '0;
      r_cur_y <= '0;
    end else begin
      r_cmd   <= w_cmd_out;
      r_mode  <= w_mode_nxt;
      r_cur_x <= w_cur_x_nxt;
      r_cur_y <= w_cur_y_nxt;
    end
  end

  assign envo_ctrl_cmd = r_cmd;
  assign mode          = r_mode;
  assign cur_x         = r_cur_x;
  assign cur_y         = r_cur_y;

endmodule

// File: tb/tb_cmd_input_ctrl.sv
// Directed bench for cmd_input_ctrl with DEB_CYCLES=4 on a 32x32 grid.
module tb_cmd_input_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] btn_dir;
  logic [7:0] btn_cmd;
  logic [7:0] envo_ctrl_cmd;
  logic       mode;
  logic [7:0] cur_x;
  logic [7:0] cur_y;

  int n_vec;
  int n_err;

  cmd_input_ctrl #(
    .GRID_W    (32),
    .GRID_H    (32),
    .DEB_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_dir      (btn_dir),
    .btn_cmd      (btn_cmd),
    .envo_ctrl_cmd(envo_ctrl_cmd),
    .mode         (mode),
    .cur_x        (cur_x),
    .cur_y        (cur_y)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive buttons, release after `hold` sampled cycles, observe for `watch` cycles.
  // Cycle k = output seen just after the k-th edge, edge 1 being the first to sample the press.
  task automatic apply_btn(input logic [3:0] dir, input logic [7:0] cmd,
                           input int hold, input int watch,
                           output int first_cyc, output logic [7:0] first_val,
                           output int n_pulse, output int chg_cyc);
    logic [7:0] x0;
    logic [7:0] y0;
    first_cyc = -1;
    first_val = 8'h00;
    n_pulse   = 0;
    chg_cyc   = -1;
    x0 = cur_x;
    y0 = cur_y;
    btn_dir = dir;
    btn_cmd = cmd;
    for (int k = 1; k <= watch; k++) begin
      tick();
      if (k == hold) begin
        btn_dir = 4'h0;
        btn_cmd = 8'h00;
      end
      if (envo_ctrl_cmd !== 8'h00) begin
        n_pulse++;
        if (first_cyc < 0) begin
          first_cyc = k;
          first_val = envo_ctrl_cmd;
        end
      end
      if (chg_cyc < 0 && (cur_x !== x0 || cur_y !== y0)) chg_cyc = k;
    end
  endtask

  int         fc;
  logic [7:0] fv;
  int         np;
  int         cc;

  task automatic test_reset();
    rst = 1'b0;
    btn_dir = 4'h0;
    btn_cmd = 8'h00;
    #3;
    n_vec++; if (envo_ctrl_cmd !== 8'h00) begin n_err++; $display("FAIL reset_cmd got=%h exp=00", envo_ctrl_cmd); end
    n_vec++; if (mode !== 1'b0) begin n_err++; $display("FAIL reset_mode got=%b exp=0", mode); end
    n_vec++; if (cur_x !== 8'd0) begin n_err++; $display("FAIL reset_cur_x got=%0d exp=0", cur_x); end
    n_vec++; if (cur_y !== 8'd0) begin n_err++; $display("FAIL reset_cur_y got=%0d exp=0", cur_y); end
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
  endtask

  task automatic test_latency();
    apply_btn(4'h0, 8'h20, 20, 34, fc, fv, np, cc);
    n_vec++; if (fc != 8) begin n_err++; $display("FAIL pattern_latency got=%0d exp=8", fc); end
    n_vec++; if (fv !== 8'h20) begin n_err++; $display("FAIL pattern_value got=%h exp=20", fv); end
    n_vec++; if (np != 1) begin n_err++; $display("FAIL pattern_count got=%0d exp=1", np); end
    n_vec++; if (mode !== 1'b0) begin n_err++; $display("FAIL pattern_mode got=%b exp=0", mode); end
  endtask

  task automatic test_glitch();
    apply_btn(4'h0, 8'h02, 3, 16, fc, fv, np, cc);
    n_vec++; if (np != 0) begin n_err++; $display("FAIL glitch_count got=%0d exp=0", np); end
    n_vec++; if (mode !== 1'b0) begin n_err++; $display("FAIL glitch_mode got=%b exp=0", mode); end
  endtask

  task automatic test_run_mode();
    apply_btn(4'h0, 8'h02, 10, 24, fc, fv, np, cc);
    n_vec++; if (fv !== 8'h02 || fc != 8) begin n_err++; $display("FAIL run_pulse got=%h@%0d exp=02@8", fv, fc); end
    n_vec++; if (mode !== 1'b1) begin n_err++; $display("FAIL run_mode got=%b exp=1", mode); end
    apply_btn(4'h0, 8'h05, 10, 24, fc, fv, np, cc);
    n_vec++; if (np != 0) begin n_err++; $display("FAIL run_gate_count got=%0d exp=0", np); end
    n_vec++; if (mode !== 1'b1) begin n_err++; $display("FAIL run_gate_mode got=%b exp=1", mode); end
    apply_btn(4'h0, 8'h40, 10, 24, fc, fv, np, cc);
    n_vec++; if (fv !== 8'h40 || np != 1) begin n_err++; $display("FAIL run_speed got=%h n=%0d exp=40 n=1", fv, np); end
  endtask

  task automatic test_clear_priority();
    apply_btn(4'h0, 8'h12, 10, 24, fc, fv, np, cc);
    n_vec++; if (fv !== 8'h12 || np != 1) begin n_err++; $display("FAIL clr_pulse got=%h n=%0d exp=12 n=1", fv, np); end
    n_vec++; if (mode !== 1'b0) begin n_err++; $display("FAIL clr_mode got=%b exp=0", mode); end
    apply_btn(4'h0, 8'h05, 10, 24, fc, fv, np, cc);
    n_vec++; if (fv !== 8'h05 || np != 1) begin n_err++; $display("FAIL edit_forward got=%h n=%0d exp=05 n=1", fv, np); end
  endtask

  task automatic test_cursor();
    apply_btn(4'b0100, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_x !== 8'd31 || cc != 8) begin n_err++; $display("FAIL left_wrap got=%0d@%0d exp=31@8", cur_x, cc); end
    n_vec++; if (np != 0) begin n_err++; $display("FAIL dir_no_cmd got=%0d exp=0", np); end
    apply_btn(4'b1000, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_x !== 8'd0) begin n_err++; $display("FAIL right_wrap got=%0d exp=0", cur_x); end
    apply_btn(4'b1000, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_x !== 8'd1) begin n_err++; $display("FAIL right_step got=%0d exp=1", cur_x); end
    apply_btn(4'b0001, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_y !== 8'd31) begin n_err++; $display("FAIL up_wrap got=%0d exp=31", cur_y); end
    apply_btn(4'b0010, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_y !== 8'd0) begin n_err++; $display("FAIL down_wrap got=%0d exp=0", cur_y); end
    apply_btn(4'b0011, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_y !== 8'd0 || cc != -1) begin n_err++; $display("FAIL up_down_cancel got=%0d chg=%0d exp=0 chg=-1", cur_y, cc); end
    apply_btn(4'b1010, 8'h00, 10, 24, fc, fv, np, cc);
    n_vec++; if (cur_x !== 8'd2 || cur_y !== 8'd1 || cc != 8) begin
      n_err++; $display("FAIL diagonal got=(%0d,%0d)@%0d exp=(2,1)@8", cur_x, cur_y, cc);
    end
  endtask

  task automatic test_mid_reset();
    apply_btn(4'h0, 8'h02, 10, 24, fc, fv, np, cc);
    n_vec++; if (mode !== 1'b1) begin n_err++; $display("FAIL pre_reset_mode got=%b exp=1", mode); end
    btn_dir = 4'b0001;
    for (int k = 1; k <= 4; k++) tick();
    rst = 1'b0;
    #1;
    n_vec++; if (cur_x !== 8'd0 || cur_y !== 8'd0) begin n_err++; $display("FAIL mid_reset_cur got=(%0d,%0d) exp=(0,0)", cur_x, cur_y); end
    n_vec++; if (mode !== 1'b0 || envo_ctrl_cmd !== 8'h00) begin n_err++; $display("FAIL mid_reset_out got=%b/%h exp=0/00", mode, envo_ctrl_cmd); end
    #2;
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 7) begin
        n_vec++; if (cur_y !== 8'd0) begin n_err++; $display("FAIL mid_reset_early got=%0d exp=0", cur_y); end
      end
      if (k == 8) begin
        n_vec++; if (cur_y !== 8'd31) begin n_err++; $display("FAIL mid_reset_wrap got=%0d exp=31", cur_y); end
      end
    end
    btn_dir = 4'h0;
    for (int k = 1; k <= 12; k++) tick();
    n_vec++; if (cur_y !== 8'd31 || cur_x !== 8'd0) begin n_err++; $display("FAIL mid_reset_hold got=(%0d,%0d) exp=(0,31)", cur_x, cur_y); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_latency();
    test_glitch();
    test_run_mode();
    test_clear_priority();
    test_cursor();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
